// File: rtl/regfile_read_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : regfile_read_arbiter
// Purpose  : Shares the register file's two read ports among NUM_REQ units,
//            with registered responses and a commit bypass.
//            `ROUND_ROBIN_EN selects round-robin, otherwise fixed priority.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_read_arbiter #(
  parameter int NUM_REQ   = 3,
  parameter int TAG_W     = 32,
  parameter int READY_TAG = 1000
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   rdy_in,
  input  logic                   clear,
  input  logic [NUM_REQ-1:0]     req_in,
  input  logic [5*NUM_REQ-1:0]   rs1_addr_in,
  input  logic [5*NUM_REQ-1:0]   rs2_addr_in,
  input  logic                   commit_we_in,
  input  logic [4:0]             commit_addr_in,
  input  logic [TAG_W-1:0]       commit_tag_in,
  input  logic [TAG_W-1:0]       commit_data_in,
  output logic                   rf_en1_out,
  output logic                   rf_en2_out,
  output logic [4:0]             rf_addr1_out,
  output logic [4:0]             rf_addr2_out,
  input  logic [TAG_W-1:0]       rf_status1_in,
  input  logic [TAG_W-1:0]       rf_status2_in,
  input  logic [TAG_W-1:0]       rf_data1_in,
  input  logic [TAG_W-1:0]       rf_data2_in,
  output logic [NUM_REQ-1:0]     rsp_valid_out,
  output logic [TAG_W-1:0]       rsp_status1_out,
  output logic [TAG_W-1:0]       rsp_status2_out,
  output logic [TAG_W-1:0]       rsp_data1_out,
  output logic [TAG_W-1:0]       rsp_data2_out
);

  localparam int                 c_idx_w     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [TAG_W-1:0]   c_ready_tag = TAG_W'(READY_TAG);
  localparam logic [NUM_REQ-1:0] c_one       = NUM_REQ'(1);

  logic [NUM_REQ-1:0] r_rsp_valid;
  logic [TAG_W-1:0]   r_status1, r_status2, r_data1, r_data2;
  logic [NUM_REQ-1:0] w_eligible;
  logic               w_found;
  logic               w_grant;
  logic [c_idx_w-1:0] w_winner;
  logic [4:0]         w_rs1, w_rs2;
  logic [TAG_W-1:0]   w_status1, w_status2, w_data1, w_data2;

  // The requester currently being answered is masked so it is not served twice.
  assign w_eligible = req_in & ~r_rsp_valid;

`ifdef ROUND_ROBIN_EN
  logic [c_idx_w-1:0] r_rr_ptr;
  logic [c_idx_w:0]   w_sum;

  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_sum    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_sum = {1'b0, r_rr_ptr} + (c_idx_w+1)'(k);
      if (w_sum >= (c_idx_w+1)'(NUM_REQ))
        w_sum = w_sum - (c_idx_w+1)'(NUM_REQ);
      if (!w_found && w_eligible[w_sum[c_idx_w-1:0]]) begin
        w_found  = 1'b1;
        w_winner = w_sum[c_idx_w-1:0];
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in)
      r_rr_ptr <= '0;
    else if (w_grant)
      r_rr_ptr <= (w_winner == c_idx_w'(NUM_REQ-1)) ? '0 : w_winner + c_idx_w'(1);
  end
`else
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!w_found && w_eligible[c_idx_w'(k)]) begin
        w_found  = 1'b1;
        w_winner = c_idx_w'(k);
      end
    end
  end
`endif

  assign w_grant = w_found && rdy_in && !clear && !rst_in;
  assign w_rs1   = rs1_addr_in[w_winner*5 +: 5];
  assign w_rs2   = rs2_addr_in[w_winner*5 +: 5];

  assign rf_en1_out   = w_grant;
  assign rf_en2_out   = w_grant;
  assign rf_addr1_out = w_grant ? w_rs1 : 5'd0;
  assign rf_addr2_out = w_grant ? w_rs2 : 5'd0;

  // x0 is hard-wired ready/zero; a matching commit supplies data, and clears
  // the pending status only if it is the producer the register file recorded.
  function automatic void resolve(
    input  logic [4:0]       addr,
    input  logic [TAG_W-1:0] rf_st,
    input  logic [TAG_W-1:0] rf_dt,
    output logic [TAG_W-1:0] st,
    output logic [TAG_W-1:0] dt
  );
    st = rf_st;
    dt = rf_dt;
    if (addr == 5'd0) begin
      st = c_ready_tag;
      dt = '0;
    end else if (commit_we_in && commit_addr_in == addr) begin
      dt = commit_data_in;
      if (commit_tag_in == rf_st)
        st = c_ready_tag;
    end
  endfunction

  always_comb begin
    resolve(w_rs1, rf_status1_in, rf_data1_in, w_status1, w_data1);
    resolve(w_rs2, rf_status2_in, rf_data2_in, w_status2, w_data2);
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_rsp_valid <= '0;
      r_status1   <= '0;
      r_status2   <= '0;
      r_data1     <= '0;
      r_data2     <= '0;
    end else if (w_grant) begin
      r_rsp_valid <= c_one << w_winner;
      r_status1   <= w_status1;
      r_status2   <= w_status2;
      r_data1     <= w_data1;
      r_data2     <= w_data2;
    end else begin
      r_rsp_valid <= '0;
    end
  end

  assign rsp_valid_out   = r_rsp_valid;
  assign rsp_status1_out = r_status1;
  assign rsp_status2_out = r_status2;
  assign rsp_data1_out   = r_data1;
  assign rsp_data2_out   = r_data2;

endmodule
`default_nettype wire

// File: tb/tb_regfile_read_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_read_arbiter
// Purpose  : Directed self-checking bench for regfile_read_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_read_arbiter;
  localparam int NR = 3;
  localparam int TW = 32;

  logic            clk_in = 1'b0;
  logic            rst_in;
  logic            rdy_in, clear;
  logic [NR-1:0]   req_in;
  logic [5*NR-1:0] rs1_addr_in, rs2_addr_in;
  logic            commit_we_in;
  logic [4:0]      commit_addr_in;
  logic [TW-1:0]   commit_tag_in, commit_data_in;
  logic            rf_en1_out, rf_en2_out;
  logic [4:0]      rf_addr1_out, rf_addr2_out;
  logic [TW-1:0]   rf_status1_in, rf_status2_in, rf_data1_in, rf_data2_in;
  logic [NR-1:0]   rsp_valid_out;
  logic [TW-1:0]   rsp_status1_out, rsp_status2_out, rsp_data1_out, rsp_data2_out;

  int checks = 0;
  int errors = 0;
  int exp_w [4];

  regfile_read_arbiter #(.NUM_REQ(NR), .TAG_W(TW), .READY_TAG(1000)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear(clear),
    .req_in(req_in), .rs1_addr_in(rs1_addr_in), .rs2_addr_in(rs2_addr_in),
    .commit_we_in(commit_we_in), .commit_addr_in(commit_addr_in),
    .commit_tag_in(commit_tag_in), .commit_data_in(commit_data_in),
    .rf_en1_out(rf_en1_out), .rf_en2_out(rf_en2_out),
    .rf_addr1_out(rf_addr1_out), .rf_addr2_out(rf_addr2_out),
    .rf_status1_in(rf_status1_in), .rf_status2_in(rf_status2_in),
    .rf_data1_in(rf_data1_in), .rf_data2_in(rf_data2_in),
    .rsp_valid_out(rsp_valid_out),
    .rsp_status1_out(rsp_status1_out), .rsp_status2_out(rsp_status2_out),
    .rsp_data1_out(rsp_data1_out), .rsp_data2_out(rsp_data2_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_in = 1'b1; rdy_in = 1'b1; clear = 1'b0; req_in = '0;
    rs1_addr_in = {5'd10, 5'd9, 5'd8};
    rs2_addr_in = {5'd18, 5'd17, 5'd16};
    commit_we_in = 1'b0; commit_addr_in = '0; commit_tag_in = '0; commit_data_in = '0;
    rf_status1_in = 1000; rf_status2_in = 1000; rf_data1_in = 32'h55; rf_data2_in = 32'h66;

    // Reset state
    repeat (2) @(posedge clk_in);
    #1;
    chk("reset_valid", 64'(rsp_valid_out), 64'd0);
    chk("reset_status1", 64'(rsp_status1_out), 64'd0);
    chk("reset_data2", 64'(rsp_data2_out), 64'd0);
    @(negedge clk_in);
    rst_in = 1'b0;

    // All requesters held high
`ifdef ROUND_ROBIN_EN
    exp_w = '{0, 1, 2, 0};
`else
    exp_w = '{0, 1, 0, 1};
`endif
    req_in = 3'b111;
    for (int g = 0; g < 4; g++) begin
      #1;
      chk($sformatf("arb_addr1_%0d", g), 64'(rf_addr1_out), 64'(8 + exp_w[g]));
      chk($sformatf("arb_addr2_%0d", g), 64'(rf_addr2_out), 64'(16 + exp_w[g]));
      chk($sformatf("arb_no_double_%0d", g), 64'(rsp_valid_out[exp_w[g]]), 64'd0);
      @(posedge clk_in); #1;
      chk($sformatf("arb_valid_%0d", g), 64'(rsp_valid_out), 64'(3'b001 << exp_w[g]));
      @(negedge clk_in);
    end
    req_in = '0;
    repeat (2) @(posedge clk_in);
    @(negedge clk_in);

    // Reset in the middle of a response
    req_in = 3'b010; rf_data1_in = 32'h77;
    @(posedge clk_in); #1;
    chk("mid_valid", 64'(rsp_valid_out), 64'b010);
    chk("mid_data1", 64'(rsp_data1_out), 64'h77);
    #2 rst_in = 1'b1;
    #1;
    chk("rst_async_valid", 64'(rsp_valid_out), 64'd0);
    chk("rst_async_data1", 64'(rsp_data1_out), 64'd0);
    chk("rst_async_status1", 64'(rsp_status1_out), 64'd0);
    chk("rst_async_en1", 64'(rf_en1_out), 64'd0);
    @(negedge clk_in);
    rst_in = 1'b0; req_in = '0;
    @(negedge clk_in);

    // Single request
    req_in = 3'b001;
    rs1_addr_in = {5'd10, 5'd9, 5'd5};
    rs2_addr_in = {5'd18, 5'd17, 5'd6};
    rf_status1_in = 1000; rf_status2_in = 1000; rf_data1_in = 11; rf_data2_in = 22;
    #1;
    chk("single_en1", 64'(rf_en1_out), 64'd1);
    chk("single_addr1", 64'(rf_addr1_out), 64'd5);
    chk("single_addr2", 64'(rf_addr2_out), 64'd6);
    @(posedge clk_in); #1;
    chk("single_valid", 64'(rsp_valid_out), 64'b001);
    chk("single_status1", 64'(rsp_status1_out), 64'd1000);
    chk("single_status2", 64'(rsp_status2_out), 64'd1000);
    chk("single_data1", 64'(rsp_data1_out), 64'd11);
    chk("single_data2", 64'(rsp_data2_out), 64'd22);
    req_in = '0; rf_data1_in = 32'h999;
    @(posedge clk_in); #1;
    chk("idle_valid", 64'(rsp_valid_out), 64'd0);
    chk("idle_hold_data1", 64'(rsp_data1_out), 64'd11);
    @(negedge clk_in);

    // Commit bypass, matching tag
    req_in = 3'b001;
    rs1_addr_in = {5'd10, 5'd9, 5'd7};
    rs2_addr_in = {5'd18, 5'd17, 5'd0};
    rf_status1_in = 4; rf_data1_in = 32'h1234;
    rf_status2_in = 32'hDEAD; rf_data2_in = 32'hBEEF;
    commit_we_in = 1'b1; commit_addr_in = 5'd7; commit_tag_in = 4; commit_data_in = 32'hABCD;
    @(posedge clk_in); #1;
    chk("byp_valid", 64'(rsp_valid_out), 64'b001);
    chk("byp_status1", 64'(rsp_status1_out), 64'd1000);
    chk("byp_data1", 64'(rsp_data1_out), 64'hABCD);
    chk("byp_x0_status2", 64'(rsp_status2_out), 64'd1000);
    chk("byp_x0_data2", 64'(rsp_data2_out), 64'd0);
    req_in = '0;
    @(posedge clk_in);
    @(negedge clk_in);

    // Commit bypass, stale tag
    req_in = 3'b001; commit_tag_in = 5;
    @(posedge clk_in); #1;
    chk("byp_stale_status1", 64'(rsp_status1_out), 64'd4);
    chk("byp_stale_data1", 64'(rsp_data1_out), 64'hABCD);
    req_in = '0;
    @(posedge clk_in);
    @(negedge clk_in);

    // Both operands x0, garbage from RF, commit aimed at x0
    req_in = 3'b001;
    rs1_addr_in = {5'd10, 5'd9, 5'd0};
    rs2_addr_in = {5'd18, 5'd17, 5'd0};
    rf_status1_in = 5; rf_status2_in = 5; rf_data1_in = 32'h99; rf_data2_in = 32'h99;
    commit_we_in = 1'b1; commit_addr_in = 5'd0; commit_tag_in = 5; commit_data_in = 32'h5555;
    @(posedge clk_in); #1;
    chk("x0_status1", 64'(rsp_status1_out), 64'd1000);
    chk("x0_status2", 64'(rsp_status2_out), 64'd1000);
    chk("x0_data1", 64'(rsp_data1_out), 64'd0);
    chk("x0_data2", 64'(rsp_data2_out), 64'd0);
    req_in = '0; commit_we_in = 1'b0;
    @(posedge clk_in);
    @(negedge clk_in);

    // Clear during a would-be grant
    req_in = 3'b001; rs1_addr_in = {5'd10, 5'd9, 5'd5}; clear = 1'b1;
    #1;
    chk("clear_en1", 64'(rf_en1_out), 64'd0);
    chk("clear_en2", 64'(rf_en2_out), 64'd0);
    @(posedge clk_in); #1;
    chk("clear_valid", 64'(rsp_valid_out), 64'd0);
    clear = 1'b0; req_in = '0;
    @(negedge clk_in);

    // Stall for three cycles, then arbitration resumes from the held pointer
    rdy_in = 1'b0; req_in = 3'b111; rs1_addr_in = {5'd10, 5'd9, 5'd8};
    for (int s = 0; s < 3; s++) begin
      #1;
      chk($sformatf("stall_en1_%0d", s), 64'(rf_en1_out), 64'd0);
      chk($sformatf("stall_addr1_%0d", s), 64'(rf_addr1_out), 64'd0);
      @(posedge clk_in); #1;
      chk($sformatf("stall_valid_%0d", s), 64'(rsp_valid_out), 64'd0);
      @(negedge clk_in);
    end
    rdy_in = 1'b1;
    #1;
`ifdef ROUND_ROBIN_EN
    chk("resume_addr1", 64'(rf_addr1_out), 64'd9);
    @(posedge clk_in); #1;
    chk("resume_valid", 64'(rsp_valid_out), 64'b010);
`else
    chk("resume_addr1", 64'(rf_addr1_out), 64'd8);
    @(posedge clk_in); #1;
    chk("resume_valid", 64'(rsp_valid_out), 64'b001);
`endif
    req_in = '0;
    @(posedge clk_in);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
